// File: rtl/in_debouncer_pkg.sv
// Shared state encodings and default parameters for the input debouncer.
package in_debouncer_pkg;
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONFIRM = 1'b1
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
endpackage

// File: rtl/in_debouncer_sync.sv
// Reset-to-0 flop chain that brings a raw asynchronous level into the clk domain.
module in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/in_debouncer.sv
// Debounces a raw pin: synchronizer, then a stability filter that flips out only after
// STABLE_CYCLES consecutive differing samples. Emits registered rise/fall strobes and busy.
module in_debouncer
  import in_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt;

  in_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    out_nxt   = out;
    case (state)
      ST_IDLE: begin
        if (s != out) begin
          state_nxt = ST_CONFIRM;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_CONFIRM: begin
        if (s == out) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          out_nxt   = ~out;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and busy are registered alongside out so all four change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= out_nxt & ~out;
      fall  <= ~out_nxt & out;
      busy  <= (state_nxt == ST_CONFIRM);
    end
  end
endmodule

// File: tb/tb_in_debouncer.sv
// Directed bench for in_debouncer at default parameters (out flips 5 edges after capture).
module tb_in_debouncer;
  logic clk = 1'b0;
  logic rst, in_r;
  logic out, rise, fall, busy;
  int   checks = 0;
  int   failures = 0;
  int   rise_cnt = 0, fall_cnt = 0, both_cnt = 0;
  int   r0, f0;

  in_debouncer dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in_r),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rise === 1'b1) rise_cnt++;
      if (fall === 1'b1) fall_cnt++;
      if (rise === 1'b1 && fall === 1'b1) both_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    in_r = 1'b0;
    tick(2);
    chk("rst_out",  out,  0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_busy", busy, 0);

    // in high while reset held: nothing may move
    in_r = 1'b1;
    tick(3);
    chk("rst_hold_out",  out,  0);
    chk("rst_hold_busy", busy, 0);
    in_r = 1'b0;
    rst  = 1'b0;
    tick(6);
    chk("settle_out", out, 0);

    // clean rise, in captured at E0
    in_r = 1'b1;
    tick(2);                       // E0+1
    chk("rise_busy_e1", busy, 0);
    tick();                        // E0+2
    chk("rise_busy_e2", busy, 1);
    chk("rise_out_e2",  out,  0);
    tick(2);                       // E0+4
    chk("rise_out_e4",  out,  0);
    chk("rise_rise_e4", rise, 0);
    tick();                        // E0+5
    chk("rise_out_e5",  out,  1);
    chk("rise_rise_e5", rise, 1);
    chk("rise_fall_e5", fall, 0);
    chk("rise_busy_e5", busy, 0);
    tick();                        // E0+6
    chk("rise_rise_e6", rise, 0);
    chk("rise_out_e6",  out,  1);
    tick(3);

    // clean fall
    in_r = 1'b0;
    tick(5);                       // E0+4
    chk("fall_out_e4",  out,  1);
    chk("fall_busy_e4", busy, 1);
    tick();                        // E0+5
    chk("fall_out_e5",  out,  0);
    chk("fall_fall_e5", fall, 1);
    chk("fall_rise_e5", rise, 0);
    tick();                        // E0+6
    chk("fall_fall_e6", fall, 0);
    chk("fall_busy_e6", busy, 0);
    tick(3);

    // bounce: 3 cycles high then back low
    r0 = rise_cnt;
    in_r = 1'b1;
    tick(3);                       // E0+2, stage0 held 1 for E0..E0+2
    in_r = 1'b0;
    tick();                        // E0+3
    chk("bnc_busy_e3", busy, 1);
    tick(2);                       // E0+5
    chk("bnc_busy_e5", busy, 0);
    chk("bnc_out_e5",  out,  0);
    tick(4);
    chk("bnc_out_end", out, 0);
    chk("bnc_no_rise", rise_cnt - r0, 0);

    // reset mid-confirm
    r0 = rise_cnt;
    in_r = 1'b1;
    tick(3);                       // E0+2
    chk("mrst_busy_e2", busy, 1);
    rst = 1'b1;
    tick();                        // E0+3 reset edge
    chk("mrst_out",  out,  0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rise", rise, 0);
    rst = 1'b0;
    tick(5);                       // E1+4
    chk("mrst_out_e4", out, 0);
    chk("mrst_no_rise", rise_cnt - r0, 0);
    tick();                        // E1+5
    chk("mrst_out_e5",  out,  1);
    chk("mrst_rise_e5", rise, 1);
    tick(3);

    // back-to-back: return low first, then 8 high / 8 low
    in_r = 1'b0;
    tick(8);
    chk("b2b_pre_out", out, 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    in_r = 1'b1;
    tick(5);                       // E0+4
    chk("b2b_out_e4", out, 0);
    tick();                        // E0+5
    chk("b2b_out_e5", out, 1);
    tick(2);                       // E0+7
    in_r = 1'b0;                   // captured at E0+8
    tick(5);                       // E0+12
    chk("b2b_out_e12", out, 1);
    tick();                        // E0+13
    chk("b2b_out_e13",  out,  0);
    chk("b2b_fall_e13", fall, 1);
    tick(6);
    chk("b2b_rises", rise_cnt - r0, 1);
    chk("b2b_falls", fall_cnt - f0, 1);
    chk("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
